// File: rtl/valu_writeback_if.sv
// Bundle of the ALU result beat, VRF write port and scalar-result FIFO port
// of the vector ALU writeback stage.
interface valu_writeback_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] in_vec;
  logic                  in_valid;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_w_reg;
  logic                  in_sca;

  logic                  vrf_wr_en;
  logic [ADDR_WIDTH-1:0] vrf_wr_addr;
  logic [DATA_WIDTH-1:0] vrf_wr_data;

  logic [DATA_WIDTH-1:0] sca_data;
  logic                  sca_valid;
  logic                  sca_ready;
  logic                  sca_overflow;
  logic [CW-1:0]         fifo_count;
  logic                  busy;

  // master: ALU pipeline plus scalar consumer; slave: the writeback stage.
  modport master (
    output in_vec, in_valid, in_addr, in_w_reg, in_sca, sca_ready,
    input  vrf_wr_en, vrf_wr_addr, vrf_wr_data,
    input  sca_data, sca_valid, sca_overflow, fifo_count, busy
  );

  modport slave (
    input  in_vec, in_valid, in_addr, in_w_reg, in_sca, sca_ready,
    output vrf_wr_en, vrf_wr_addr, vrf_wr_data,
    output sca_data, sca_valid, sca_overflow, fifo_count, busy
  );
endinterface

// File: rtl/valu_writeback.sv
// Vector ALU writeback: registers VRF writes one cycle after the result beat and
// buffers scalar results in a first-word-fall-through FIFO with a sticky overflow flag.
module valu_writeback #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  valu_writeback_if.slave wb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;

  logic                  vrf_en;
  logic [ADDR_WIDTH-1:0] vrf_addr;
  logic [DATA_WIDTH-1:0] vrf_data;

  logic                  vrf_req;
  logic                  push_req;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    vrf_req  = wb.in_valid & wb.in_w_reg;
    push_req = wb.in_valid & wb.in_sca;
    full     = (count == FULL_COUNT);
    do_pop   = (count != '0) & wb.sca_ready;
    do_push  = push_req & (~full | do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      vrf_en   <= 1'b0;
      vrf_addr <= '0;
      vrf_data <= '0;
    end else begin
      vrf_en   <= vrf_req;
      vrf_addr <= vrf_req ? wb.in_addr : '0;
      vrf_data <= vrf_req ? wb.in_vec  : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
      if (push_req && full && !do_pop) overflow <= 1'b1;
    end
  end

  // NOTE: storage is cleared on reset because the head is visible on sca_data
  // immediately and must read 0 until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wb.in_vec;
    end
  end

  assign wb.vrf_wr_en    = vrf_en;
  assign wb.vrf_wr_addr  = vrf_addr;
  assign wb.vrf_wr_data  = vrf_data;
  assign wb.sca_data     = mem[rd_ptr];
  assign wb.sca_valid    = (count != '0);
  assign wb.sca_overflow = overflow;
  assign wb.fifo_count   = count;
  assign wb.busy         = vrf_en | (count != '0);
endmodule

// File: tb/tb_valu_writeback.sv
// Self-checking bench for valu_writeback: directed scenarios plus a randomized run,
// all checked against a queue-based model of the writeback rules.
module tb_valu_writeback;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  valu_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

  valu_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, expressed directly in terms of the behavioural rules.
  logic [DW-1:0] q[$];
  bit            m_ovf;
  bit            m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_pushed;

  task automatic drive(input bit v, input bit wr, input bit sc,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rdy);
    bus.in_valid  = v;
    bus.in_w_reg  = wr;
    bus.in_sca    = sc;
    bus.in_addr   = a;
    bus.in_vec    = d;
    bus.sca_ready = rdy;
  endtask

  // Apply the rules to the inputs currently driven, then advance one clock.
  task automatic tick();
    bit pop, push;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_en = 0; m_addr = '0; m_data = '0; m_pushed = 0;
    end else begin
      m_en   = bus.in_valid && bus.in_w_reg;
      m_addr = m_en ? bus.in_addr : '0;
      m_data = m_en ? bus.in_vec  : '0;
      pop  = (q.size() != 0) && bus.sca_ready;
      push = bus.in_valid && bus.in_sca;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) begin
          q.push_back(bus.in_vec);
          m_pushed = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 1, 32'h44, 64'h1234, 1);
    tick(); tick();
    rst = 1'b0;
    drive(0, 0, 0, '0, '0, 0);
    n_cmp++; if (bus.vrf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_vrf_en: got %b want 0", bus.vrf_wr_en); end
    n_cmp++; if (bus.vrf_wr_addr !== '0) begin n_fail++; $display("FAIL reset_vrf_addr: got %h want 0", bus.vrf_wr_addr); end
    n_cmp++; if (bus.vrf_wr_data !== '0) begin n_fail++; $display("FAIL reset_vrf_data: got %h want 0", bus.vrf_wr_data); end
    n_cmp++; if (bus.fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    n_cmp++; if (bus.sca_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sca_valid: got %b want 0", bus.sca_valid); end
    n_cmp++; if (bus.sca_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.sca_overflow); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.sca_data !== '0) begin n_fail++; $display("FAIL reset_sca_data: got %h want 0", bus.sca_data); end
  endtask

  task automatic test_vrf_write();
    drive(1, 1, 0, 32'h10, 64'hDEAD, 0);
    tick();
    drive(0, 0, 0, '0, '0, 0);
    n_cmp++; if (bus.vrf_wr_en !== 1'b1) begin n_fail++; $display("FAIL vrf_en: got %b want 1", bus.vrf_wr_en); end
    n_cmp++; if (bus.vrf_wr_addr !== 32'h10) begin n_fail++; $display("FAIL vrf_addr: got %h want 10", bus.vrf_wr_addr); end
    n_cmp++; if (bus.vrf_wr_data !== 64'hDEAD) begin n_fail++; $display("FAIL vrf_data: got %h want dead", bus.vrf_wr_data); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL vrf_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.fifo_count !== '0) begin n_fail++; $display("FAIL vrf_no_push: got %0d want 0", bus.fifo_count); end
    tick();
    n_cmp++; if (bus.vrf_wr_en !== 1'b0) begin n_fail++; $display("FAIL vrf_en_drop: got %b want 0", bus.vrf_wr_en); end
    n_cmp++; if (bus.vrf_wr_addr !== '0 || bus.vrf_wr_data !== '0) begin
      n_fail++; $display("FAIL vrf_idle_zero: got addr %h data %h want 0/0", bus.vrf_wr_addr, bus.vrf_wr_data);
    end
  endtask

  task automatic test_ordering();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 1, '0, DW'(i), 0);
      tick();
    end
    drive(0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.sca_valid !== 1'b1 || bus.sca_data !== DW'(i + 1)) begin
        n_fail++; $display("FAIL order_data[%0d]: got v=%b %h want v=1 %h", i, bus.sca_valid, bus.sca_data, DW'(i + 1));
      end
      n_cmp++; if (bus.fifo_count !== CW'(3 - i)) begin
        n_fail++; $display("FAIL order_count[%0d]: got %0d want %0d", i, bus.fifo_count, 3 - i);
      end
      tick();
    end
    n_cmp++; if (bus.sca_valid !== 1'b0 || bus.fifo_count !== '0) begin
      n_fail++; $display("FAIL order_empty: got v=%b cnt=%0d want v=0 cnt=0", bus.sca_valid, bus.fifo_count);
    end
    drive(0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_dual_flag();
    drive(1, 1, 1, 32'h20, 64'h55, 0);
    tick();
    drive(0, 0, 0, '0, '0, 1);
    n_cmp++; if (bus.vrf_wr_en !== 1'b1 || bus.vrf_wr_data !== 64'h55) begin
      n_fail++; $display("FAIL dual_vrf: got en=%b %h want en=1 55", bus.vrf_wr_en, bus.vrf_wr_data);
    end
    n_cmp++; if (bus.sca_valid !== 1'b1 || bus.sca_data !== 64'h55) begin
      n_fail++; $display("FAIL dual_sca: got v=%b %h want v=1 55", bus.sca_valid, bus.sca_data);
    end
    tick();
    drive(0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] vals [5];
    for (int i = 0; i < 5; i++) vals[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, '0, vals[i], 0);
      tick();
    end
    drive(1, 0, 1, '0, vals[4], 1);
    tick();
    drive(0, 0, 0, '0, '0, 1);
    n_cmp++; if (bus.fifo_count !== CW'(4) || bus.sca_overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_pushpop: got cnt=%0d ovf=%b want cnt=4 ovf=0", bus.fifo_count, bus.sca_overflow);
    end
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (bus.sca_data !== vals[i]) begin
        n_fail++; $display("FAIL full_drain[%0d]: got %h want %h", i, bus.sca_data, vals[i]);
      end
      tick();
    end
    drive(0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_overflow();
    logic [DW-1:0] vals [5];
    for (int i = 0; i < 5; i++) vals[i] = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, '0, vals[i], 0);
      tick();
    end
    drive(0, 0, 0, '0, '0, 1);
    n_cmp++; if (bus.fifo_count !== CW'(4) || bus.sca_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: got cnt=%0d ovf=%b want cnt=4 ovf=1", bus.fifo_count, bus.sca_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.sca_data !== vals[i]) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, bus.sca_data, vals[i]);
      end
      tick();
    end
    n_cmp++; if (bus.sca_overflow !== 1'b1 || bus.sca_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sticky: got ovf=%b v=%b want ovf=1 v=0", bus.sca_overflow, bus.sca_valid);
    end
    drive(0, 0, 0, '0, '0, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 2, 1, 32'h30, {$urandom, $urandom}, 0);
      tick();
    end
    drive(0, 0, 0, '0, '0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.fifo_count !== '0 || bus.sca_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_fifo: got cnt=%0d v=%b want 0/0", bus.fifo_count, bus.sca_valid);
    end
    n_cmp++; if (bus.sca_overflow !== 1'b0 || bus.busy !== 1'b0 || bus.vrf_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags: got ovf=%b busy=%b en=%b want 0/0/0", bus.sca_overflow, bus.busy, bus.vrf_wr_en);
    end
    n_cmp++; if (bus.sca_data !== '0) begin
      n_fail++; $display("FAIL rstmid_data: got %h want 0", bus.sca_data);
    end
  endtask

  task automatic test_ignored();
    drive(0, 1, 1, 32'h40, 64'h77, 1);
    tick();
    n_cmp++; if (bus.vrf_wr_en !== 1'b0 || bus.fifo_count !== '0) begin
      n_fail++; $display("FAIL ign_invalid: got en=%b cnt=%0d want 0/0", bus.vrf_wr_en, bus.fifo_count);
    end
    drive(1, 0, 0, 32'h40, 64'h77, 1);
    tick();
    n_cmp++; if (bus.vrf_wr_en !== 1'b0 || bus.fifo_count !== '0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL ign_noflag: got en=%b cnt=%0d busy=%b want 0/0/0", bus.vrf_wr_en, bus.fifo_count, bus.busy);
    end
    drive(1, 0, 1, '0, 64'h99, 1);
    tick();
    drive(0, 0, 0, '0, '0, 0);
    n_cmp++; if (bus.fifo_count !== CW'(1) || bus.sca_data !== 64'h99) begin
      n_fail++; $display("FAIL empty_pushpop: got cnt=%0d %h want 1 99", bus.fifo_count, bus.sca_data);
    end
    bus.sca_ready = 1'b1;
    tick();
    bus.sca_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, 2) != 0,
            $urandom, {$urandom, $urandom}, $urandom_range(0, 2) == 0);
      tick();
      n_cmp++; if (bus.vrf_wr_en !== m_en || bus.vrf_wr_addr !== m_addr || bus.vrf_wr_data !== m_data) begin
        n_fail++; $display("FAIL rnd_vrf @%0d: got %b %h %h want %b %h %h", c,
                           bus.vrf_wr_en, bus.vrf_wr_addr, bus.vrf_wr_data, m_en, m_addr, m_data);
      end
      n_cmp++; if (bus.fifo_count !== CW'(q.size()) || bus.sca_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_count @%0d: got %0d v=%b want %0d", c, bus.fifo_count, bus.sca_valid, q.size());
      end
      n_cmp++; if (bus.sca_overflow !== m_ovf || bus.busy !== (m_en || q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_flags @%0d: got ovf=%b busy=%b want ovf=%b busy=%b", c,
                           bus.sca_overflow, bus.busy, m_ovf, m_en || q.size() != 0);
      end
      if (q.size() != 0) begin
        n_cmp++; if (bus.sca_data !== q[0]) begin
          n_fail++; $display("FAIL rnd_head @%0d: got %h want %h", c, bus.sca_data, q[0]);
        end
      end else if (!m_pushed) begin
        n_cmp++; if (bus.sca_data !== '0) begin
          n_fail++; $display("FAIL rnd_head0 @%0d: got %h want 0", c, bus.sca_data);
        end
      end
    end
    rst = 1'b0;
    drive(0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    drive(0, 0, 0, '0, '0, 0);
    test_reset();
    test_vrf_write();
    test_ordering();
    test_dual_flag();
    test_full_push_pop();
    test_overflow();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
